uart_rx_ctrl: RTL
=================

# uart_rx_ctrl

UART receive controller that sequences the oversampled bit-phase counter through start, data and stop bits, recovering one byte per frame. Sits between the raw `rx` pin and the command/decode logic, driven by the shared oversample tick `baud_en`. Performs the 3-sample majority vote at phases CENTER-1/CENTER/CENTER+1, validates start bits and flags framing errors.

## Interface
- `OVERSAMPLE`, 16: baud_en ticks per bit; must be ≥ 4; CENTER = OVERSAMPLE/2.
- `DATA_BITS`, 8: payload bits per frame, LSB first; 5–9 legal.
- `clk`  in  1  system clock; one clock only.
- `rst_n`  in  1  asynchronous, active-low reset.
- `baud_en`  in  1  oversample enable, one clk wide, OVERSAMPLE pulses per bit period.
- `rx`  in  1  asynchronous serial line, idle high.
- `data_out`  out  DATA_BITS  last good byte; holds until next good frame.
- `data_valid`  out  1  one-clk pulse, data_out updated this cycle.
- `frame_err`  out  1  one-clk pulse, stop bit sampled low.
- `busy`  out  1  high in any state except IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer (reset value 1) → `rx_s`; all decisions use `rx_s`.
- States: IDLE, START, DATA, STOP, WAIT_IDLE. Phase register `ph` has width clog2(OVERSAMPLE); bit index `idx` has width clog2(DATA_BITS).
- State and phase advance only on `baud_en`; with `baud_en` low, all state, phase and shift registers hold.
- IDLE: a tick with `rx_s`=0 → START, `ph`<=1 (the detect tick counts as phase 0).
- Active states: each tick `ph`<=`ph`+1, wrapping OVERSAMPLE-1→0.
- Vote: ticks with `ph` ∈ {CENTER-1, CENTER, CENTER+1} shift `rx_s` into a 3-bit window. At the CENTER+1 tick, bit = majority(window including the current sample).
- START: at decision, majority 1 → IDLE (false start, no output pulse); majority 0 → continue. At the `ph`=OVERSAMPLE-1 tick → DATA, `idx`<=0.
- DATA: at decision, shift the bit into the MSB of the shift register (LSB-first reception). At the `ph`=OVERSAMPLE-1 tick, `idx`==DATA_BITS-1 → STOP, else `idx`+1.
- STOP: at decision, majority 1 → `data_out`<=shift register, `data_valid` pulse, IDLE. Majority 0 → `frame_err` pulse, `data_out` unchanged, WAIT_IDLE. The early return at mid-stop-bit is deliberate: it resynchronizes on the next start edge.
- WAIT_IDLE: the first tick with `rx_s`=1 → IDLE. A break condition (line held low) stays here.
- `data_valid` and `frame_err` are never high together, and never high outside STOP decisions.

## Timing
- Reset (asynchronous, any state including mid-frame): state IDLE, `ph`=0, `idx`=0, window=0, `data_out`=0, `data_valid`=0, `frame_err`=0, `busy`=0, synchronizer flops=1.
- All outputs are registered. A pulse is high in the clk cycle after the edge on which the STOP decision tick is sampled, for exactly one cycle.
- Latency from the start-bit falling edge on `rx` to `data_valid`: 2 clk (synchronizer) plus at most 1 tick (detect), then (1+DATA_BITS)·OVERSAMPLE + CENTER+1 ticks, plus 1 clk.
- `busy` rises the clk after the detect tick and falls the clk after the return to IDLE.
- The start edge of a back-to-back frame, arriving at `ph`≥CENTER+2 of the previous stop bit, must be detected.

## Structure
- Shared package `uart_pkg`: state enum (IDLE, START, DATA, STOP, WAIT_IDLE), default OVERSAMPLE/DATA_BITS constants, CENTER localparam derivation.
- One sub-module, `rx_phase_gen`. It has:
  - inputs: `clk`, `rst_n`, `baud_en`, `load1`, `run`;
  - outputs: `ph`, `vote_win` (ph in window), `vote_done` (ph=CENTER+1), `bit_end` (ph=OVERSAMPLE-1).
- The FSM, synchronizer, voter and shift register stay in the top level.

## Test plan
All scenarios use OVERSAMPLE=16, DATA_BITS=8, and `baud_en` every 4 clk.
- Frame 0xA5 with a clean stop bit → `data_out`=0xA5, exactly one `data_valid` pulse, `frame_err` never high, `busy` high for 9·16+10 ticks ±1.
- `rx` low for 3 ticks then high → no `data_valid`; `busy` drops after the CENTER+1 tick of START.
- Frame 0x00 with a 1-tick high spike at `ph`=8 of bit 3 → majority rejects the spike, `data_out`=0x00.
- Frame 0x3C with the stop bit low for 2 bit periods, then high → `frame_err` pulse, `data_out` keeps its prior value, state WAIT_IDLE until `rx` high, then 0x55 received correctly.
- `rst_n` asserted during bit 4 of a frame → all outputs 0 immediately, no pulse; the following frame 0x81 is received correctly.
- Back-to-back frames 0xFF, 0x00 with no idle gap → two `data_valid` pulses, values in order; the second start edge is detected within 1 tick.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding,
// default frame geometry, mid-bit centre derivation and the bit voter.
package uart_pkg;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int DATA_BITS_DEF  = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } rx_state_e;

    // Phase at which a bit is nominally centred.
    function automatic int center_of(input int oversample);
        return oversample / 2;
    endfunction

    // Two-out-of-three majority used to reject single-sample glitches.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/rx_phase_gen.sv
// Oversample phase counter for the UART receiver. Counts baud_en ticks
// within one bit period and decodes the voting window, the decision
// phase and the last phase of the bit.
module rx_phase_gen
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          baud_en,
    input  logic                          load1,
    input  logic                          run,
    output logic [$clog2(OVERSAMPLE)-1:0] ph,
    output logic                          vote_win,
    output logic                          vote_done,
    output logic                          bit_end
);

    localparam int PH_W   = $clog2(OVERSAMPLE);
    localparam int CENTER = center_of(OVERSAMPLE);

    localparam logic [PH_W-1:0] PH_ZERO  = {PH_W{1'b0}};
    localparam logic [PH_W-1:0] PH_ONE   = PH_W'(1);
    localparam logic [PH_W-1:0] PH_LO    = PH_W'(CENTER - 1);
    localparam logic [PH_W-1:0] PH_HI    = PH_W'(CENTER + 1);
    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(OVERSAMPLE - 1);

    logic [PH_W-1:0] ph_r;

    // Phase advances only on oversample ticks; the detect tick is phase 0,
    // so a fresh frame starts counting from 1. Idle holds the counter at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_r <= PH_ZERO;
        end else if (baud_en) begin
            if (load1) begin
                ph_r <= PH_ONE;
            end else if (run) begin
                ph_r <= (ph_r == PH_LAST) ? PH_ZERO : (ph_r + PH_ONE);
            end else begin
                ph_r <= PH_ZERO;
            end
        end else begin
            ph_r <= ph_r;
        end
    end

    assign ph        = ph_r;
    assign vote_win  = (ph_r >= PH_LO) && (ph_r <= PH_HI);
    assign vote_done = (ph_r == PH_HI);
    assign bit_end   = (ph_r == PH_LAST);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: synchronizes rx, walks start/data/stop bits
// with a 3-sample majority vote around mid-bit, and delivers one byte per
// frame with a valid pulse or a framing-error pulse.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DATA_BITS  = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_en,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int PH_W  = $clog2(OVERSAMPLE);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [PH_W-1:0]  PH_ZERO  = {PH_W{1'b0}};

    // Synchronizer
    logic rx_meta_r;
    logic rx_sync_r;
    logic rx_s;

    // FSM and datapath state
    rx_state_e            state_r, state_s;
    logic [IDX_W-1:0]     idx_r, idx_s;
    logic [2:0]           win_r, win_s;
    logic [DATA_BITS-1:0] shreg_r, shreg_s;
    logic [DATA_BITS-1:0] data_out_r, data_out_s;
    logic                 data_valid_r, data_valid_s;
    logic                 frame_err_r, frame_err_s;
    logic                 busy_r;

    // Phase generator hookup
    logic [PH_W-1:0] ph_s;
    logic            vote_win_s;
    logic            vote_done_s;
    logic            bit_end_s;
    logic            load1_s;
    logic            run_s;
    logic            bit_s;

    // Two-flop synchronizer; resets to the idle line level so reset never
    // looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    assign rx_s  = rx_sync_r;
    assign run_s = (state_r != IDLE);

    rx_phase_gen #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_phase (
        .clk       (clk),
        .rst_n     (rst_n),
        .baud_en   (baud_en),
        .load1     (load1_s),
        .run       (run_s),
        .ph        (ph_s),
        .vote_win  (vote_win_s),
        .vote_done (vote_done_s),
        .bit_end   (bit_end_s)
    );

    // Bit decision: the two earlier window samples plus the live sample.
    assign bit_s = maj3(win_r[1], win_r[0], rx_s);

    // Next-state, voter window, shift register and output pulse logic.
    always_comb begin
        state_s      = state_r;
        idx_s        = idx_r;
        win_s        = win_r;
        shreg_s      = shreg_r;
        data_out_s   = data_out_r;
        data_valid_s = 1'b0;
        frame_err_s  = 1'b0;
        load1_s      = 1'b0;

        if (baud_en) begin
            // Each bit starts with an empty window so no sample from the
            // previous bit can ever take part in a vote.
            if (ph_s == PH_ZERO) begin
                win_s = 3'b000;
            end else if (vote_win_s && (state_r != IDLE)) begin
                win_s = {win_r[1:0], rx_s};
            end else begin
                win_s = win_r;
            end

            case (state_r)
                IDLE: begin
                    if (!rx_s) begin
                        state_s = START;
                        load1_s = 1'b1;
                    end else begin
                        state_s = IDLE;
                    end
                end

                START: begin
                    if (vote_done_s && bit_s) begin
                        // Glitch, not a real start bit.
                        state_s = IDLE;
                    end else if (bit_end_s) begin
                        state_s = DATA;
                        idx_s   = IDX_ZERO;
                    end else begin
                        state_s = START;
                    end
                end

                DATA: begin
                    if (vote_done_s) begin
                        shreg_s = {bit_s, shreg_r[DATA_BITS-1:1]};
                    end else begin
                        shreg_s = shreg_r;
                    end
                    if (bit_end_s) begin
                        if (idx_r == IDX_LAST) begin
                            state_s = STOP;
                        end else begin
                            idx_s = idx_r + IDX_ONE;
                        end
                    end else begin
                        idx_s = idx_r;
                    end
                end

                STOP: begin
                    // Leave at mid-stop-bit so a back-to-back start edge
                    // is seen by IDLE.
                    if (vote_done_s) begin
                        if (bit_s) begin
                            data_out_s   = shreg_r;
                            data_valid_s = 1'b1;
                            state_s      = IDLE;
                        end else begin
                            frame_err_s  = 1'b1;
                            state_s      = WAIT_IDLE;
                        end
                    end else begin
                        state_s = STOP;
                    end
                end

                WAIT_IDLE: begin
                    if (rx_s) begin
                        state_s = IDLE;
                    end else begin
                        state_s = WAIT_IDLE;
                    end
                end

                default: begin
                    state_s = IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // FSM, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            idx_r        <= IDX_ZERO;
            win_r        <= 3'b000;
            shreg_r      <= {DATA_BITS{1'b0}};
            data_out_r   <= {DATA_BITS{1'b0}};
            data_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            idx_r        <= idx_s;
            win_r        <= win_s;
            shreg_r      <= shreg_s;
            data_out_r   <= data_out_s;
            data_valid_r <= data_valid_s;
            frame_err_r  <= frame_err_s;
            busy_r       <= (state_s != IDLE);
        end
    end

    assign data_out   = data_out_r;
    assign data_valid = data_valid_r;
    assign frame_err  = frame_err_r;
    assign busy       = busy_r;

endmodule
